// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine: LANES columns per beat,
// 4/LANES beats per 128-bit block, valid/ready on both sides.
module mix_columns_engine #(
  parameter int          LANES = 1,
  parameter logic [7:0]  POLY  = 8'h1b
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [1:0]   fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and its payload stable until that edge.

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_columns_engine: LANES must be 1, 2 or 4");
  end

  localparam int         BEATS  = 4 / LANES;
  localparam logic [1:0] LAST   = 2'(BEATS - 1);
  localparam logic [1:0] LANE_W = 2'(LANES);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q;
  logic [1:0]        col_cnt;
  logic              mode_q;
  logic [3:0][31:0]  work_q;
  logic [3:0][31:0]  work_nxt;
  logic [1:0]        slot;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (POLY & {8{x[7]}});
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] s  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m3[i] = x2[i] ^ s[i];
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    // Row r uses the circulant matrix rotated right by r.
    for (int r = 0; r < 4; r++) begin
      if (inv)
        res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      else
        res[31-8*r -: 8] = x2[r] ^ m3[(r+1)%4] ^ s[(r+2)%4] ^ s[(r+3)%4];
    end
    return res;
  endfunction

  // Column c lives in work_q[3-c], so the slot index is the bitwise inverse.
  always_comb begin
    work_nxt = work_q;
    slot     = '0;
    for (int l = 0; l < LANES; l++) begin
      slot           = ~(col_cnt * LANE_W + 2'(l));
      work_nxt[slot] = mix_col(work_q[slot], mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      col_cnt   <= '0;
      mode_q    <= 1'b0;
      work_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q   <= in_data;
            mode_q   <= in_inv;
            col_cnt  <= '0;
            in_ready <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          work_q  <= work_nxt;
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == LAST) begin
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = work_q;
  assign fsm_state = state_q;

endmodule
